// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock under start/busy/done
module seq_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] i,
  output logic [2*N-1:0] o,
  output logic           carry,
  output logic           busy,
  output logic           done
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, nxt;
  logic [N:0] rem, rn;
  logic [N-1:0] quo, qn, yd, x, y;
  logic [CW-1:0] cnt;
  logic [N+1:0] sh;
  logic ge, last;
  assign x = i[N-1:0];
  assign y = i[2*N-1:N];
  // shifted partial remainder carries one extra bit so the compare cannot overflow
  assign sh = {rem, quo[N-1]};
  assign ge = sh >= {2'b0, yd};
  assign rn = ge ? (N+1)'(sh - {2'b0, yd}) : sh[N:0];
  assign qn = {quo[N-2:0], ge};
  assign last = cnt == CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == S_IDLE ? (start ? (y == '0 ? S_DONE : S_RUN) : S_IDLE) :
          state == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
  end
  always_comb begin
    busy = state != S_IDLE;
    done = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem   <= '0;
      quo   <= '0;
      yd    <= '0;
      cnt   <= '0;
      o     <= '0;
      carry <= 1'b0;
    end else if (state == S_IDLE && start) begin
      rem <= '0;
      quo <= x;
      yd  <= y;
      cnt <= CW'(N);
      if (y == '0) begin
        o     <= {x, {N{1'b1}}};
        carry <= 1'b1;
      end
    end else if (state == S_RUN) begin
      rem <= rn;
      quo <= qn;
      cnt <= cnt - 1'b1;
      if (last) begin
        o     <= {rn[N-1:0], qn};
        carry <= 1'b0;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;
  logic clk, rst_n, start, carry, busy, done;
  logic [7:0] i, o;
  int npass = 0, ntot = 0;

  seq_divider #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i(i),
    .o(o), .carry(carry), .busy(busy), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", npass, ntot);
    $fatal(1);
  end

  // {carry, o}
  function automatic logic [8:0] model(input logic [7:0] v);
    int x, y;
    x = v[3:0];
    y = v[7:4];
    if (y == 0) return {1'b1, v[3:0], 4'hF};
    return {1'b0, 4'(x % y), 4'(x / y)};
  endfunction

  function automatic int model_lat(input logic [7:0] v);
    return v[7:4] == 0 ? 1 : 6 - 1;
  endfunction

  // lat = negedges from the start edge until done is seen
  task automatic run_div(input logic [7:0] v, output int lat, output logic [7:0] res,
                         output logic c, output logic bz_ok, output logic hold_ok);
    logic [7:0] prev;
    @(negedge clk);
    bz_ok = (busy === 1'b0);
    hold_ok = 1'b1;
    prev = o;
    i = v;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    i = 8'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bz_ok &= (busy === 1'b1);
      if (!done) hold_ok &= (o === prev);
    end while (!done && lat < 20);
    res = o;
    c = carry;
  endtask

  task automatic test_reset;
    rst_n = 0; start = 0; i = 0;
    #1;
    ntot++; if (o !== 8'h00) $display("FAIL reset_o: got %h want 00", o); else npass++;
    ntot++; if ({carry, busy, done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {carry, busy, done}); else npass++;
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic;
    logic [7:0] vin [3] = '{8'h3D, 8'h1F, 8'h95};
    logic [7:0] vexp [3] = '{8'h14, 8'h0F, 8'h50};
    int lat; logic [7:0] r; logic c, b, h;
    for (int k = 0; k < 3; k++) begin
      run_div(vin[k], lat, r, c, b, h);
      ntot++; if (r !== vexp[k]) $display("FAIL basic_o[%h]: got %h want %h", vin[k], r, vexp[k]); else npass++;
      ntot++; if (c !== 1'b0) $display("FAIL basic_carry[%h]: got %b want 0", vin[k], c); else npass++;
      ntot++; if (lat !== 5) $display("FAIL basic_lat[%h]: got %0d want 5", vin[k], lat); else npass++;
      ntot++; if (h !== 1'b1) $display("FAIL basic_hold[%h]: o changed before done", vin[k]); else npass++;
    end
  endtask

  task automatic test_div_zero;
    int lat; logic [7:0] r; logic c, b, h;
    run_div(8'h07, lat, r, c, b, h);
    ntot++; if (r !== 8'h7F) $display("FAIL dz_o: got %h want 7f", r); else npass++;
    ntot++; if (c !== 1'b1) $display("FAIL dz_carry: got %b want 1", c); else npass++;
    ntot++; if (lat !== 1) $display("FAIL dz_lat: got %0d want 1", lat); else npass++;
    ntot++; if (b !== 1'b1) $display("FAIL dz_busy: busy window wrong"); else npass++;
    run_div(8'h3D, lat, r, c, b, h);
    ntot++; if ({c, r} !== 9'h014) $display("FAIL dz_after: got %b/%h want 0/14", c, r); else npass++;
    ntot++; if (h !== 1'b1) $display("FAIL dz_hold: carry/o changed before done"); else npass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    logic [7:0] v;
    logic [8:0] e;
    int last = -1, cyc = 0, got = 0;
    start = 1;
    while (got < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        e = model(q.pop_front());
        ntot++; if ({carry, o} !== e) $display("FAIL b2b_result[%0d]: got %b/%h want %b/%h", got, carry, o, e[8], e[7:0]); else npass++;
        if (last >= 0) begin
          ntot++; if (cyc - last !== 6) $display("FAIL b2b_period[%0d]: got %0d want 6", got, cyc - last); else npass++;
        end
        last = cyc;
        got++;
      end
      if (!busy) begin
        v = {4'($urandom_range(1, 15)), 4'($urandom)};
        q.push_back(v);
        i = v;
      end else i = 8'($urandom);
    end
    start = 0;
    ntot++; if (got !== 5) $display("FAIL b2b_count: got %0d want 5", got); else npass++;
  endtask

  task automatic test_reset_mid;
    int lat; logic [7:0] r; logic c, b, h;
    @(negedge clk);
    i = 8'h3D;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    ntot++; if (o !== 8'h00) $display("FAIL rstmid_o: got %h want 00", o); else npass++;
    ntot++; if ({carry, busy, done} !== 3'b000) $display("FAIL rstmid_flags: got %b want 000", {carry, busy, done}); else npass++;
    @(negedge clk);
    rst_n = 1;
    run_div(8'hE9, lat, r, c, b, h);
    ntot++; if ({c, r} !== model(8'hE9)) $display("FAIL rstmid_after: got %b/%h want %h", c, r, model(8'hE9)); else npass++;
    ntot++; if (lat !== 5) $display("FAIL rstmid_lat: got %0d want 5", lat); else npass++;
  endtask

  task automatic test_sweep;
    int lat; logic [7:0] r, v; logic c, b, h;
    logic [8:0] e;
    for (int k = 0; k < 256; k++) begin
      v = 8'(k);
      e = model(v);
      run_div(v, lat, r, c, b, h);
      ntot++; if ({c, r} !== e) $display("FAIL sweep_result[%h]: got %b/%h want %b/%h", v, c, r, e[8], e[7:0]); else npass++;
      ntot++; if (lat !== model_lat(v)) $display("FAIL sweep_lat[%h]: got %0d want %0d", v, lat, model_lat(v)); else npass++;
      ntot++; if (b !== 1'b1) $display("FAIL sweep_busy[%h]: busy not high exactly from start edge through done", v); else npass++;
    end
    @(negedge clk);
    ntot++; if ({busy, done} !== 2'b00) $display("FAIL sweep_idle: got %b want 00", {busy, done}); else npass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
